// File: rtl/branch_recovery_ctrl_if.sv
// Bundle between branch arbitration, ROB/rename status and the recovery
// consumers (fetch, rename, LSQ).
interface branch_recovery_ctrl_if #(
    parameter int SQN_W = 6,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic             IN_branchTaken;
    logic [PC_W-1:0]  IN_branchDstPC;
    logic [SQN_W-1:0] IN_branchSqN;
    logic [SQN_W-1:0] IN_branchLoadSqN;
    logic [SQN_W-1:0] IN_branchStoreSqN;
    logic             IN_branchFlush;
    logic [SQN_W-1:0] IN_ROB_curSqN;
    logic [SQN_W-1:0] IN_RN_nextSqN;

    logic             OUT_redirectValid;
    logic [PC_W-1:0]  OUT_redirectPC;
    logic             OUT_rnRollbackValid;
    logic [SQN_W-1:0] OUT_rnNextSqN;
    logic             OUT_lsqRollbackValid;
    logic [SQN_W-1:0] OUT_lsqLoadSqN;
    logic [SQN_W-1:0] OUT_lsqStoreSqN;
    logic             OUT_stall;
    logic             OUT_busy;
    logic [CNT_W-1:0] OUT_recoveryCount;

    // Environment side: drives branch/status, observes recovery outputs.
    modport master (
        output IN_branchTaken, IN_branchDstPC, IN_branchSqN, IN_branchLoadSqN,
               IN_branchStoreSqN, IN_branchFlush, IN_ROB_curSqN, IN_RN_nextSqN,
        input  OUT_redirectValid, OUT_redirectPC, OUT_rnRollbackValid, OUT_rnNextSqN,
               OUT_lsqRollbackValid, OUT_lsqLoadSqN, OUT_lsqStoreSqN, OUT_stall,
               OUT_busy, OUT_recoveryCount
    );

    // Recovery controller side.
    modport slave (
        input  IN_branchTaken, IN_branchDstPC, IN_branchSqN, IN_branchLoadSqN,
               IN_branchStoreSqN, IN_branchFlush, IN_ROB_curSqN, IN_RN_nextSqN,
        output OUT_redirectValid, OUT_redirectPC, OUT_rnRollbackValid, OUT_rnNextSqN,
               OUT_lsqRollbackValid, OUT_lsqLoadSqN, OUT_lsqStoreSqN, OUT_stall,
               OUT_busy, OUT_recoveryCount
    );
endinterface

// File: rtl/branch_recovery_ctrl.sv
// Branch recovery sequencer: turns the arbitrated mispredict into one-cycle
// redirect/rollback pulses, then stalls the frontend until the ROB has
// drained to the rename point (equality seen on two consecutive cycles).
module branch_recovery_ctrl #(
    parameter int SQN_W = 6,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    branch_recovery_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2,
        SETTLE   = 2'd3
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [SQN_W-1:0]        cap_sqn;
    logic signed [SQN_W-1:0] sqn_diff;
    logic                    older;
    logic                    accept;
    logic                    drained;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Flush squashes the branch itself; otherwise rename resumes just after it.
    function automatic logic [SQN_W-1:0] rollback_sqn(input logic [SQN_W-1:0] sqn,
                                                      input logic flush);
        return flush ? sqn : sqn + 1'b1;
    endfunction

    // Age compare by signed modular difference so sqN wrap-around is harmless.
    assign sqn_diff = $signed(bus.IN_branchSqN - cap_sqn);
    assign older    = sqn_diff[SQN_W-1];
    assign accept   = bus.IN_branchTaken && ((state_q == IDLE) || older);
    assign drained  = (bus.IN_ROB_curSqN == bus.IN_RN_nextSqN);

    // Next-state logic; a newly accepted older branch always restarts at REDIRECT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept) state_d = REDIRECT;
            REDIRECT: state_d = accept ? REDIRECT : DRAIN;
            DRAIN: begin
                if (accept)       state_d = REDIRECT;
                else if (drained) state_d = SETTLE;
            end
            SETTLE: begin
                if (accept)       state_d = REDIRECT;
                else if (drained) state_d = IDLE;
                else              state_d = DRAIN;
            end
            default:  state_d = IDLE;
        endcase
    end

    // State register, branch capture and fully registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q                  <= IDLE;
            cap_sqn                  <= '0;
            bus.OUT_redirectValid    <= 1'b0;
            bus.OUT_redirectPC       <= '0;
            bus.OUT_rnRollbackValid  <= 1'b0;
            bus.OUT_rnNextSqN        <= '0;
            bus.OUT_lsqRollbackValid <= 1'b0;
            bus.OUT_lsqLoadSqN       <= '0;
            bus.OUT_lsqStoreSqN      <= '0;
            bus.OUT_stall            <= 1'b0;
            bus.OUT_busy             <= 1'b0;
            bus.OUT_recoveryCount    <= '0;
        end else begin
            state_q                  <= state_d;
            bus.OUT_stall            <= (state_d != IDLE);
            bus.OUT_busy             <= (state_d != IDLE);
            bus.OUT_redirectValid    <= accept;
            bus.OUT_rnRollbackValid  <= accept;
            bus.OUT_lsqRollbackValid <= accept;
            if (accept) begin
                cap_sqn                <= bus.IN_branchSqN;
                bus.OUT_redirectPC     <= bus.IN_branchDstPC;
                bus.OUT_rnNextSqN      <= rollback_sqn(bus.IN_branchSqN, bus.IN_branchFlush);
                bus.OUT_lsqLoadSqN     <= bus.IN_branchLoadSqN;
                bus.OUT_lsqStoreSqN    <= bus.IN_branchStoreSqN;
                bus.OUT_recoveryCount  <= sat_inc(bus.OUT_recoveryCount);
            end
        end
    end
endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Directed bench for branch_recovery_ctrl.
module tb_branch_recovery_ctrl;
    localparam int SQN_W = 6;
    localparam int PC_W  = 32;
    localparam int CNT_W = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    branch_recovery_ctrl_if #(.SQN_W(SQN_W), .PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    branch_recovery_ctrl #(.SQN_W(SQN_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic branch(input logic [31:0] pc, input logic [5:0] sqn,
                          input logic [5:0] ld, input logic [5:0] st, input logic fl);
        bus.IN_branchTaken    = 1'b1;
        bus.IN_branchDstPC    = pc;
        bus.IN_branchSqN      = sqn;
        bus.IN_branchLoadSqN  = ld;
        bus.IN_branchStoreSqN = st;
        bus.IN_branchFlush    = fl;
    endtask

    task automatic rob(input logic [5:0] cur, input logic [5:0] nxt);
        bus.IN_ROB_curSqN = cur;
        bus.IN_RN_nextSqN = nxt;
    endtask

    task automatic expect_pulse(input string tag, input logic [31:0] pc, input logic [5:0] rn,
                                input logic [5:0] ld, input logic [5:0] st, input logic [15:0] cnt);
        check({tag, ".redirectValid"}, bus.OUT_redirectValid, 1);
        check({tag, ".rnValid"}, bus.OUT_rnRollbackValid, 1);
        check({tag, ".lsqValid"}, bus.OUT_lsqRollbackValid, 1);
        check({tag, ".pc"}, bus.OUT_redirectPC, pc);
        check({tag, ".rnNextSqN"}, bus.OUT_rnNextSqN, rn);
        check({tag, ".load"}, bus.OUT_lsqLoadSqN, ld);
        check({tag, ".store"}, bus.OUT_lsqStoreSqN, st);
        check({tag, ".stall"}, bus.OUT_stall, 1);
        check({tag, ".count"}, bus.OUT_recoveryCount, cnt);
    endtask

    task automatic expect_quiet(input string tag, input logic stall, input logic [15:0] cnt);
        check({tag, ".redirectValid"}, bus.OUT_redirectValid, 0);
        check({tag, ".rnValid"}, bus.OUT_rnRollbackValid, 0);
        check({tag, ".lsqValid"}, bus.OUT_lsqRollbackValid, 0);
        check({tag, ".stall"}, bus.OUT_stall, stall);
        check({tag, ".busy"}, bus.OUT_busy, stall);
        check({tag, ".count"}, bus.OUT_recoveryCount, cnt);
    endtask

    // Two consecutive equal samples end the recovery.
    task automatic drain_out(input string tag, input logic [15:0] cnt);
        rob(6'd9, 6'd9);
        tick();
        expect_quiet({tag, ".settle"}, 1'b1, cnt);
        tick();
        expect_quiet({tag, ".idle"}, 1'b0, cnt);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.IN_branchTaken = 1'b0;
        bus.IN_branchDstPC = '0;
        bus.IN_branchSqN = '0;
        bus.IN_branchLoadSqN = '0;
        bus.IN_branchStoreSqN = '0;
        bus.IN_branchFlush = 1'b0;
        rob(6'd0, 6'd5);
        tick();
        tick();
        rst = 1'b0;
        expect_quiet("reset", 1'b0, 16'd0);
        check("reset.pc", bus.OUT_redirectPC, 0);
        check("reset.rnNextSqN", bus.OUT_rnNextSqN, 0);
        check("reset.load", bus.OUT_lsqLoadSqN, 0);

        // Basic accept, flush=0; no pulse in the accept cycle itself.
        branch(32'h1000, 6'd10, 6'd3, 6'd4, 1'b0);
        #1;
        check("t1.noComb", bus.OUT_redirectValid, 0);
        tick();
        bus.IN_branchTaken = 1'b0;
        expect_pulse("t1", 32'h1000, 6'd11, 6'd3, 6'd4, 16'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_quiet("t1.drain", 1'b1, 16'd1);
        end
        check("t1.pcHold", bus.OUT_redirectPC, 32'h1000);
        drain_out("t1", 16'd1);

        // flush=1 keeps rename at the branch sqN; equal-unequal-equal-equal drain.
        branch(32'h1000, 6'd10, 6'd3, 6'd4, 1'b1);
        tick();
        bus.IN_branchTaken = 1'b0;
        rob(6'd0, 6'd5);
        expect_pulse("t2", 32'h1000, 6'd10, 6'd3, 6'd4, 16'd2);
        tick();
        expect_quiet("t2.drain", 1'b1, 16'd2);
        rob(6'd7, 6'd7);
        tick();
        expect_quiet("t2.settle1", 1'b1, 16'd2);
        rob(6'd7, 6'd8);
        tick();
        expect_quiet("t2.backToDrain", 1'b1, 16'd2);
        rob(6'd8, 6'd8);
        tick();
        expect_quiet("t2.settle2", 1'b1, 16'd2);
        tick();
        expect_quiet("t2.idle", 1'b0, 16'd2);

        // Younger branch ignored during DRAIN, older one restarts recovery.
        branch(32'h1000, 6'd10, 6'd3, 6'd4, 1'b0);
        rob(6'd0, 6'd5);
        tick();
        bus.IN_branchTaken = 1'b0;
        expect_pulse("t3", 32'h1000, 6'd11, 6'd3, 6'd4, 16'd3);
        tick();
        branch(32'h2000, 6'd12, 6'd1, 6'd2, 1'b0);
        tick();
        expect_quiet("t3.younger", 1'b1, 16'd3);
        check("t3.pcKept", bus.OUT_redirectPC, 32'h1000);
        branch(32'h2000, 6'd7, 6'd1, 6'd2, 1'b0);
        tick();
        bus.IN_branchTaken = 1'b0;
        expect_pulse("t3.older", 32'h2000, 6'd8, 6'd1, 6'd2, 16'd4);
        tick();
        expect_quiet("t3.drain", 1'b1, 16'd4);

        // Reset mid-recovery clears everything with no pulse.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_quiet("t4.rst", 1'b0, 16'd0);
        check("t4.pc", bus.OUT_redirectPC, 0);
        check("t4.rnNextSqN", bus.OUT_rnNextSqN, 0);
        check("t4.store", bus.OUT_lsqStoreSqN, 0);

        // Wrap-around: active 62, taken 1 is younger.
        branch(32'h40, 6'd62, 6'd60, 6'd61, 1'b0);
        tick();
        bus.IN_branchTaken = 1'b0;
        expect_pulse("t5", 32'h40, 6'd63, 6'd60, 6'd61, 16'd1);
        tick();
        branch(32'h44, 6'd1, 6'd0, 6'd0, 1'b0);
        tick();
        bus.IN_branchTaken = 1'b0;
        expect_quiet("t5.wrapYounger", 1'b1, 16'd1);
        drain_out("t5", 16'd1);

        // Wrap-around: active 1, taken 62 is older.
        branch(32'h80, 6'd1, 6'd1, 6'd1, 1'b0);
        rob(6'd0, 6'd5);
        tick();
        bus.IN_branchTaken = 1'b0;
        expect_pulse("t6", 32'h80, 6'd2, 6'd1, 6'd1, 16'd2);
        tick();
        branch(32'h84, 6'd62, 6'd58, 6'd59, 1'b0);
        tick();
        bus.IN_branchTaken = 1'b0;
        expect_pulse("t6.wrapOlder", 32'h84, 6'd63, 6'd58, 6'd59, 16'd3);
        tick();
        drain_out("t6", 16'd3);

        // sqN=63 without flush wraps rename to 0; older branch accepted in REDIRECT.
        branch(32'hC0, 6'd63, 6'd62, 6'd61, 1'b0);
        rob(6'd0, 6'd5);
        tick();
        branch(32'h3000, 6'd60, 6'd7, 6'd8, 1'b1);
        expect_pulse("t7.first", 32'hC0, 6'd0, 6'd62, 6'd61, 16'd4);
        tick();
        bus.IN_branchTaken = 1'b0;
        expect_pulse("t7.second", 32'h3000, 6'd60, 6'd7, 6'd8, 16'd5);
        tick();
        expect_quiet("t7.drain", 1'b1, 16'd5);
        drain_out("t7", 16'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
